core_dbg_initiator: RTL and testbench
=====================================

// Module: core_dbg_initiator
// PURPOSE
// - Initiator end of dbg_intf. Accepts one debug request (cmd/addr/data) from a host-side front end
//   (UART/JTAG bridge), drives it onto dbg_intf, waits for dut_done, and returns one response.
// - Sits between the host transport and the core debug responder. Guarantees one execution per request.
// PARAMETERS
// - TIMEOUT_CYCLES  1024  WAIT cycles without dut_done before abort (only with DBG_TIMEOUT_EN); >=2
// PORTS
// - clk          in   1   single clock, all logic posedge
// - rstn_i       in   1   asynchronous active-low reset
// - req_valid_i  in   1   request valid
// - req_ready_o  out  1   request accepted when valid&ready
// - req_cmd_i    in   8   command 0x00-0x06 (NOP,HALT,RESUME,RD_REG,WR_REG,RD_PC,WR_PC)
// - req_addr_i   in   32  register index for RD_REG/WR_REG (bits [4:0] used by responder)
// - req_data_i   in   32  write data for WR_REG/WR_PC
// - rsp_valid_o  out  1   response valid, held until rsp_ready_i
// - rsp_ready_i  in   1   response consumed when valid&ready
// - rsp_data_o   out  32  read data (RD_REG/RD_PC), else 0
// - rsp_err_o    out  1   1 = unsupported command or timeout
// - busy_o       out  1   high in any state except IDLE
// - dbg_bus      intf -   dbg_intf.dbg modport: drives cmd[7:0], addr[31:0], data_dbg_dut[31:0];
//                         samples dut_done, data_dut_dbg[31:0]
// BEHAVIOUR
// - Reset values: req_ready_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, busy_o=0, cmd=0, addr=0,
//   data_dbg_dut=0. All outputs registered; FSM enters IDLE.
// - FSM states: IDLE, ISSUE, WAIT, GAP, RESP.
// - IDLE: req_ready_o=1. On accept, latch cmd/addr/data.
//   - cmd==0x00: go to RESP with data=0, err=0. No bus activity.
//   - cmd>0x06: go to RESP with err=1. No bus activity.
//   - otherwise: go to ISSUE.
// - ISSUE: drive the latched cmd/addr/data on dbg_bus for one cycle, then go to WAIT.
//   Bus fields stay stable until dut_done is seen.
// - WAIT: hold cmd. In the cycle dut_done=1, capture data_dut_dbg into rsp_data_o, but only for
//   RD_REG/RD_PC; else 0. Then drive cmd=0 from the next cycle and go to GAP.
//   dut_done sampled in ISSUE is ignored.
// - GAP: cmd=0 for exactly 2 cycles; dut_done is ignored (a trailing done from the responder's
//   registered handshake must not complete the next request). Then go to RESP.
// - RESP: rsp_valid_o=1, data and err stable. On rsp_ready_i go to IDLE.
//   req_ready_o reasserts the following cycle (no request/response overlap).
// - Latency: NOP/illegal request reaches rsp_valid 1 cycle after accept.
//   Bus command: accept -> rsp_valid = 1(ISSUE) + N(WAIT, N>=1) + 2(GAP) + 1 cycles.
// - Only one request in flight; req_ready_o=0 outside IDLE.
// - Async reset mid-operation: all state and outputs return to reset values immediately and cmd drops
//   to 0. The in-flight request is lost, with no response. Halt state inside the core is not restored.
// - rsp_valid & rsp_ready in the same cycle as a new req_valid: the request is not accepted that cycle.
// CONFIGURATION
// - DBG_TIMEOUT_EN defined: 16-bit cycle counter, cleared on entering WAIT, increments each WAIT cycle.
//   At TIMEOUT_CYCLES with no dut_done: cmd=0, rsp_err=1, rsp_data=0, go to GAP.
//   dut_done and timeout in the same cycle: done wins, err=0.
// - DBG_TIMEOUT_EN undefined: no counter; WAIT is unbounded; rsp_err_o asserts only for illegal cmd.
// STRUCTURE
// - dbg_pkg: DBG_CMD_NOP..DBG_CMD_WR_PC localparams (8-bit), DBG_CMD_MAX=8'h06,
//   typedef enum logic[2:0] dbg_init_state_t.
// - Sub-module dbg_timeout_ctr (clk, rstn_i, clr, en, expired), instantiated only under DBG_TIMEOUT_EN.
// - FSM, request latch and response register live in core_dbg_initiator.
// TESTING
// - RD_PC, responder returns 0x0000_1234 with done 3 cycles after cmd -> rsp_data=0x0000_1234, err=0;
//   cmd=0 for 2 cycles before rsp_valid.
// - WR_REG addr=5 data=0xCAFE_F00D -> dbg_bus addr=5, data_dbg_dut=0xCAFE_F00D stable until done;
//   rsp_data=0.
// - Request cmd=0x07 -> rsp_valid 1 cycle after accept, err=1, dbg_bus.cmd stays 0 throughout.
// - Responder holds done high 2 cycles; back-to-back HALT then RESUME -> exactly one response each,
//   each cmd visible once.
// - DBG_TIMEOUT_EN, TIMEOUT_CYCLES=16, responder never done -> err=1 after 16 WAIT cycles, cmd=0;
//   done on cycle 16 -> err=0.
// - rstn_i low during WAIT of RD_REG -> cmd=0 and rsp_valid=0 same cycle; next request completes normally.

Source files
------------

// File: rtl/dbg_pkg.sv
// dbg_pkg: shared definitions for the debug initiator/responder pair.
// Contents: 8-bit debug command codes, the highest legal command code,
// the initiator FSM state type and a read-command helper.
package dbg_pkg;

   localparam logic [7:0] DBG_CMD_NOP    = 8'h00;
   localparam logic [7:0] DBG_CMD_HALT   = 8'h01;
   localparam logic [7:0] DBG_CMD_RESUME = 8'h02;
   localparam logic [7:0] DBG_CMD_RD_REG = 8'h03;
   localparam logic [7:0] DBG_CMD_WR_REG = 8'h04;
   localparam logic [7:0] DBG_CMD_RD_PC  = 8'h05;
   localparam logic [7:0] DBG_CMD_WR_PC  = 8'h06;
   localparam logic [7:0] DBG_CMD_MAX    = 8'h06;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_GAP   = 3'd3,
      ST_RESP  = 3'd4
   } dbg_init_state_t;

   // Only these commands return data from the responder.
   function automatic logic dbg_cmd_is_read(input logic [7:0] cmd);
      return (cmd == DBG_CMD_RD_REG) || (cmd == DBG_CMD_RD_PC);
   endfunction

endpackage

// File: rtl/dbg_intf.sv
// dbg_intf: debug bus between the initiator and the core debug responder.
// Signals: cmd[7:0], addr[31:0], data_dbg_dut[31:0] (initiator -> responder);
//          dut_done, data_dut_dbg[31:0] (responder -> initiator).
// Modports: dbg (initiator side), dut (responder side).
interface dbg_intf;
   logic [7:0]  cmd;
   logic [31:0] addr;
   logic [31:0] data_dbg_dut;
   logic        dut_done;
   logic [31:0] data_dut_dbg;

   modport dbg (output cmd, output addr, output data_dbg_dut,
                input dut_done, input data_dut_dbg);
   modport dut (input cmd, input addr, input data_dbg_dut,
                output dut_done, output data_dut_dbg);
endinterface

// File: rtl/dbg_timeout_ctr.sv
// dbg_timeout_ctr: 16-bit WAIT-cycle counter used by core_dbg_initiator.
// Only present when DBG_TIMEOUT_EN is defined.
// Ports: clk, rstn_i (async active-low), clr (zero the count),
//        en (count this cycle), expired (en is high in the LIMIT-th counted cycle).
`ifdef DBG_TIMEOUT_EN
module dbg_timeout_ctr #(
   parameter int unsigned LIMIT = 1024
) (
   input  logic clk,
   input  logic rstn_i,
   input  logic clr,
   input  logic en,
   output logic expired
);

   // Count holds (n-1) during the n-th enabled cycle.
   localparam logic [15:0] LAST = 16'(LIMIT - 1);

   logic [15:0] cnt_reg;

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_reg <= '0;
      end else if (clr) begin
         cnt_reg <= '0;
      end else if (en && !expired) begin
         cnt_reg <= cnt_reg + 16'd1;
      end
   end

   assign expired = en && (cnt_reg == LAST);

endmodule
`endif

// File: rtl/core_dbg_initiator.sv
// core_dbg_initiator: initiator end of dbg_intf. Takes one host request
// (cmd/addr/data), issues it on the debug bus, waits for dut_done, and returns
// exactly one response. Only one request is ever in flight.
// Optional feature macro: DBG_TIMEOUT_EN (adds TIMEOUT_CYCLES WAIT timeout).
// Ports:
//   clk, rstn_i (async active-low)
//   req_valid_i/req_ready_o, req_cmd_i[7:0], req_addr_i[31:0], req_data_i[31:0]
//   rsp_valid_o/rsp_ready_i, rsp_data_o[31:0], rsp_err_o
//   busy_o (not IDLE), dbg_bus (dbg_intf.dbg)
module core_dbg_initiator
    import dbg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
)
(
    input  logic        clk,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [7:0]  req_cmd_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    dbg_intf.dbg        dbg_bus
);

    dbg_init_state_t state_reg, state_next;

    logic        req_ready_reg;
    logic        rsp_valid_reg;
    logic [31:0] rsp_data_reg;
    logic        rsp_err_reg;
    logic        busy_reg;
    logic [7:0]  cmd_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic        gap_reg;     // set during the second GAP cycle

    logic accept;
    logic cmd_nop;
    logic cmd_illegal;
    logic timeout;

    assign accept      = req_valid_i && req_ready_reg;
    assign cmd_nop     = (req_cmd_i == DBG_CMD_NOP);
    assign cmd_illegal = (req_cmd_i > DBG_CMD_MAX);

`ifdef DBG_TIMEOUT_EN
    dbg_timeout_ctr #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clk     (clk),
        .rstn_i  (rstn_i),
        .clr     (state_reg == ST_ISSUE),
        .en      (state_reg == ST_WAIT),
        .expired (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    // NOP and illegal commands never touch the bus.
                    if (cmd_nop || cmd_illegal) state_next = ST_RESP;
                    else                        state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (dbg_bus.dut_done || timeout) state_next = ST_GAP;
            end
            // dut_done is deliberately ignored here: the responder may still be
            // holding done from the request that just finished.
            ST_GAP: begin
                if (gap_reg) state_next = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready_i) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // All outputs are registered; status flags are derived from the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            req_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            cmd_reg       <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            gap_reg       <= 1'b0;
        end else begin
            req_ready_reg <= (state_next == ST_IDLE);
            busy_reg      <= (state_next != ST_IDLE);
            rsp_valid_reg <= (state_next == ST_RESP);
            gap_reg       <= (state_reg == ST_GAP) ? ~gap_reg : 1'b0;

            if (accept) begin
                rsp_data_reg <= '0;
                rsp_err_reg  <= cmd_illegal;
                if (!cmd_nop && !cmd_illegal) begin
                    cmd_reg   <= req_cmd_i;
                    addr_reg  <= req_addr_i;
                    wdata_reg <= req_data_i;
                end
            end

            if (state_reg == ST_WAIT) begin
                // done takes priority over a timeout in the same cycle
                if (dbg_bus.dut_done) begin
                    rsp_data_reg <= dbg_cmd_is_read(cmd_reg) ? dbg_bus.data_dut_dbg : 32'd0;
                    rsp_err_reg  <= 1'b0;
                    cmd_reg      <= '0;
                end else if (timeout) begin
                    rsp_data_reg <= '0;
                    rsp_err_reg  <= 1'b1;
                    cmd_reg      <= '0;
                end
            end
        end
    end

    assign req_ready_o          = req_ready_reg;
    assign rsp_valid_o          = rsp_valid_reg;
    assign rsp_data_o           = rsp_data_reg;
    assign rsp_err_o            = rsp_err_reg;
    assign busy_o               = busy_reg;
    assign dbg_bus.cmd          = cmd_reg;
    assign dbg_bus.addr         = addr_reg;
    assign dbg_bus.data_dbg_dut = wdata_reg;

endmodule

// File: tb/tb_core_dbg_initiator.sv
// tb_core_dbg_initiator: directed self-checking bench for core_dbg_initiator
// with a small configurable responder model on dbg_intf.
module tb_core_dbg_initiator;
    import dbg_pkg::*;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_cmd;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;

    dbg_intf bus ();

    core_dbg_initiator #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rstn_i      (rstn),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_cmd_i   (req_cmd),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_data_o  (rsp_data),
        .rsp_err_o   (rsp_err),
        .busy_o      (busy),
        .dbg_bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- responder model ----------------
    // done is raised rsp_delay cycles after the cycle the command first appears,
    // and held for rsp_hold cycles.
    int          rsp_delay = 3;
    int          rsp_hold  = 1;
    logic        rsp_never = 1'b0;
    logic [31:0] rsp_rdata = 32'd0;

    logic [7:0]  prev_cmd;
    logic        active;
    int          since;
    int          rise_cnt [8];
    logic [31:0] seen_addr;
    logic [31:0] seen_data;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prev_cmd <= 8'h00;
            active   <= 1'b0;
            since    <= 0;
        end else begin
            prev_cmd <= bus.cmd;
            if (bus.cmd != 8'h00 && prev_cmd == 8'h00) begin
                active    <= 1'b1;
                since     <= 1;
                rise_cnt[bus.cmd[2:0]] <= rise_cnt[bus.cmd[2:0]] + 1;
                seen_addr <= bus.addr;
                seen_data <= bus.data_dbg_dut;
            end else if (active) begin
                since <= since + 1;
            end
        end
    end

    assign bus.dut_done     = active && !rsp_never && (since >= rsp_delay) && (since < rsp_delay + rsp_hold);
    assign bus.data_dut_dbg = rsp_rdata;

    // ---------------- monitors ----------------
    int acc_cnt = 0;
    int hs_cnt  = 0;
    always @(posedge clk) begin
        if (req_valid && req_ready) acc_cnt <= acc_cnt + 1;
        if (rsp_valid && rsp_ready) hs_cnt  <= hs_cnt + 1;
    end

    logic        mon_en   = 1'b0;
    logic [31:0] mon_addr = 32'd0;
    logic [31:0] mon_data = 32'd0;
    int          stable_err = 0;
    always @(negedge clk) begin
        if (mon_en && bus.cmd != 8'h00 && (bus.addr != mon_addr || bus.data_dbg_dut != mon_data))
            stable_err <= stable_err + 1;
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    logic [31:0] last_rd;
    logic        last_err;
    int          last_lat;
    int          last_nz;
    logic [1:0]  last_gap;

    // Called at a negedge; returns at a negedge with the response consumed.
    // Latency counts cycles after the accept cycle until rsp_valid is seen.
    task automatic do_req(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_cmd   = c;
        req_addr  = a;
        req_data  = d;
        @(posedge clk);
        #1 req_valid = 1'b0;
        last_lat = 0;
        last_nz  = 0;
        last_gap = 2'b00;
        do begin
            @(negedge clk);
            last_lat++;
            if (!rsp_valid) begin
                last_gap = {last_gap[0], bus.cmd == 8'h00};
                if (bus.cmd != 8'h00) last_nz++;
            end
        end while (!rsp_valid && last_lat < 200);
        last_rd  = rsp_data;
        last_err = rsp_err;
        $display("TXN cmd=%02h addr=%08h data=%08h -> rsp_data=%08h err=%0b latency=%0d",
                 c, a, d, last_rd, last_err, last_lat);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, hs0, r1, r2, se0;
        rstn      = 1'b0;
        req_valid = 1'b0;
        req_cmd   = 8'h00;
        req_addr  = 32'd0;
        req_data  = 32'd0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        // reset state
        check_val("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check_val("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("rst_rsp_data",  rsp_data, 32'd0);
        check_val("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
        check_val("rst_busy",      {31'd0, busy}, 32'd0);
        check_val("rst_cmd",       {24'd0, bus.cmd}, 32'd0);
        check_val("rst_addr",      bus.addr, 32'd0);
        check_val("rst_wdata",     bus.data_dbg_dut, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check_val("idle_ready", {31'd0, req_ready}, 32'd1);

        // RD_PC, done 3 cycles after cmd
        rsp_delay = 3; rsp_hold = 1; rsp_rdata = 32'h0000_1234;
        do_req(DBG_CMD_RD_PC, 32'd0, 32'd0);
        check_val("rdpc_data", last_rd, 32'h0000_1234);
        check_val("rdpc_err",  {31'd0, last_err}, 32'd0);
        check_val("rdpc_lat",  last_lat, 32'd7);
        check_val("rdpc_gap",  {30'd0, last_gap}, 32'd3);
        check_val("rdpc_cmd_cycles", last_nz, 32'd4);

        // WR_REG: bus fields stable until done, no read data returned
        rsp_delay = 4; rsp_rdata = 32'hDEAD_BEEF;
        mon_addr = 32'd5; mon_data = 32'hCAFE_F00D; mon_en = 1'b1;
        se0 = stable_err;
        do_req(DBG_CMD_WR_REG, 32'd5, 32'hCAFE_F00D);
        mon_en = 1'b0;
        check_val("wr_data",   last_rd, 32'd0);
        check_val("wr_err",    {31'd0, last_err}, 32'd0);
        check_val("wr_lat",    last_lat, 32'd8);
        check_val("wr_stable", stable_err - se0, 32'd0);
        check_val("wr_addr",   seen_addr, 32'd5);
        check_val("wr_wdata",  seen_data, 32'hCAFE_F00D);

        // RD_REG with minimum wait
        rsp_delay = 1; rsp_rdata = 32'hA5A5_0003;
        do_req(DBG_CMD_RD_REG, 32'd3, 32'd0);
        check_val("rdreg_data", last_rd, 32'hA5A5_0003);
        check_val("rdreg_lat",  last_lat, 32'd5);

        // illegal commands and NOP: no bus activity, 1-cycle response
        do_req(8'h07, 32'd0, 32'd0);
        check_val("ill7_err",  {31'd0, last_err}, 32'd1);
        check_val("ill7_data", last_rd, 32'd0);
        check_val("ill7_lat",  last_lat, 32'd1);
        check_val("ill7_bus",  last_nz, 32'd0);
        do_req(8'hFF, 32'd0, 32'd0);
        check_val("illff_err", {31'd0, last_err}, 32'd1);
        check_val("illff_lat", last_lat, 32'd1);
        do_req(DBG_CMD_NOP, 32'd0, 32'd0);
        check_val("nop_err",  {31'd0, last_err}, 32'd0);
        check_val("nop_data", last_rd, 32'd0);
        check_val("nop_lat",  last_lat, 32'd1);
        check_val("nop_bus",  last_nz, 32'd0);

        // done held 2 cycles; back-to-back HALT then RESUME
        rsp_delay = 2; rsp_hold = 2; rsp_rdata = 32'h1111_2222;
        r1 = rise_cnt[1]; r2 = rise_cnt[2]; hs0 = hs_cnt;
        do_req(DBG_CMD_HALT, 32'd0, 32'd0);
        check_val("halt_lat",  last_lat, 32'd6);
        check_val("halt_data", last_rd, 32'd0);
        do_req(DBG_CMD_RESUME, 32'd0, 32'd0);
        check_val("resume_lat", last_lat, 32'd6);
        check_val("resume_err", {31'd0, last_err}, 32'd0);
        check_val("halt_seen",   rise_cnt[1] - r1, 32'd1);
        check_val("resume_seen", rise_cnt[2] - r2, 32'd1);
        check_val("b2b_rsp_cnt", hs_cnt - hs0, 32'd2);
        check_val("b2b_idle_valid", {31'd0, rsp_valid}, 32'd0);
        rsp_hold = 1;

        // response handshake and new request in the same cycle
        req_valid = 1'b1; req_cmd = DBG_CMD_NOP;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check_val("ovl_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        acc0 = acc_cnt; hs0 = hs_cnt;
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check_val("ovl_no_accept", acc_cnt - acc0, 32'd0);
        check_val("ovl_rsp_hs",    hs_cnt - hs0, 32'd1);
        check_val("ovl_ready_back", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        check_val("ovl_accept_next", acc_cnt - acc0, 32'd1);
        @(negedge clk);
        check_val("ovl_second_rsp", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        @(negedge clk);

`ifdef DBG_TIMEOUT_EN
        // responder never answers: abort after 16 WAIT cycles
        rsp_never = 1'b1;
        do_req(DBG_CMD_RD_REG, 32'd1, 32'd0);
        check_val("to_err",  {31'd0, last_err}, 32'd1);
        check_val("to_data", last_rd, 32'd0);
        check_val("to_lat",  last_lat, 32'd20);
        check_val("to_gap",  {30'd0, last_gap}, 32'd3);
        rsp_never = 1'b0;
        // done in the 16th WAIT cycle wins over the timeout
        rsp_delay = 16; rsp_rdata = 32'h0000_BEEF;
        do_req(DBG_CMD_RD_REG, 32'd1, 32'd0);
        check_val("to_edge_err",  {31'd0, last_err}, 32'd0);
        check_val("to_edge_data", last_rd, 32'h0000_BEEF);
        check_val("to_edge_lat",  last_lat, 32'd20);
`else
        // without the timeout a long wait still completes cleanly
        rsp_delay = 40; rsp_rdata = 32'h0BAD_F00D;
        do_req(DBG_CMD_RD_PC, 32'd0, 32'd0);
        check_val("long_err",  {31'd0, last_err}, 32'd0);
        check_val("long_data", last_rd, 32'h0BAD_F00D);
        check_val("long_lat",  last_lat, 32'd44);
`endif

        // async reset during WAIT of RD_REG
        rsp_never = 1'b1;
        req_valid = 1'b1; req_cmd = DBG_CMD_RD_REG; req_addr = 32'd2;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_val("mid_busy", {31'd0, busy}, 32'd1);
        check_val("mid_cmd",  {24'd0, bus.cmd}, {24'd0, DBG_CMD_RD_REG});
        #2 rstn = 1'b0;
        #1;
        check_val("arst_cmd",       {24'd0, bus.cmd}, 32'd0);
        check_val("arst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_val("arst_busy",      {31'd0, busy}, 32'd0);
        @(negedge clk);
        rstn = 1'b1; rsp_never = 1'b0;
        $display("TXN cmd=%02h addr=%08h dropped by reset", DBG_CMD_RD_REG, 32'd2);
        @(negedge clk);
        rsp_delay = 2; rsp_rdata = 32'h7777_0007;
        do_req(DBG_CMD_RD_REG, 32'd7, 32'd0);
        check_val("post_rst_data", last_rd, 32'h7777_0007);
        check_val("post_rst_err",  {31'd0, last_err}, 32'd0);
        check_val("post_rst_lat",  last_lat, 32'd6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
